// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath: fetch/decode/execute/memory/write-back sequencing.
// Optional MCTRL_ILLEGAL_TRAP_EN: unrecognized opcodes park the FSM in TRAP instead of retiring as a NOP.

module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       BranchNe,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] ALUOp,
  output logic       instr_done,
  output logic [3:0] state
);

  // state    | meaning
  // IDLE     | one cycle after reset before the first fetch
  // FETCH    | read instruction at PC, PC += 4 when memory is ready
  // DECODE   | latch opcode, compute branch target into ALUOut
  // MEM_ADDR | effective address for lw/sw
  // MEM_RD   | data read, waits on mem_ready
  // MEM_WB   | load result to rt
  // MEM_WR   | data write, waits on mem_ready
  // R_EXEC   | R-type ALU operation
  // R_WB     | R-type result to rd
  // BRANCH   | beq/bne compare and conditional PC write
  // JUMP     | PC <= jump target
  // I_EXEC   | immediate ALU operation
  // I_WB     | immediate result to rt
  // TRAP     | illegal opcode, held until reset (optional)
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EXEC   = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_I_EXEC   = 4'd11,
    S_I_WB     = 4'd12
`ifdef MCTRL_ILLEGAL_TRAP_EN
    , S_TRAP   = 4'd13
`endif
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic       op_legal;

  logic       pcwr_q, pcwr_d, pcc_q, pcc_d, bne_q, bne_d, iord_q, iord_d;
  logic       mrd_q, mrd_d, mwr_q, mwr_d, rdst_q, rdst_d, m2r_q, m2r_d;
  logic       rwr_q, rwr_d, asa_q, asa_d, done_q, done_d;
  logic [1:0] asb_q, asb_d, pcs_q, pcs_d;
  logic [2:0] aluop_q, aluop_d;

  always_comb begin
    op_legal = 1'b0;
    case (opcode)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_J,
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI, OP_SLTIU: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE:     state_d = S_FETCH;
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        op_d = opcode;
        if (!op_legal) begin
`ifdef MCTRL_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          state_d = S_FETCH;
`endif
        end else begin
          case (opcode)
            OP_LW, OP_SW:   state_d = S_MEM_ADDR;
            OP_RTYPE:       state_d = S_R_EXEC;
            OP_BEQ, OP_BNE: state_d = S_BRANCH;
            OP_J:           state_d = S_JUMP;
            default:        state_d = S_I_EXEC;
          endcase
        end
      end
      S_MEM_ADDR: state_d = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_R_EXEC:   state_d = S_R_WB;
      S_I_EXEC:   state_d = S_I_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_I_WB: state_d = S_FETCH;
`ifdef MCTRL_ILLEGAL_TRAP_EN
      S_TRAP:     state_d = S_TRAP;
`endif
      default:    state_d = S_IDLE;
    endcase

    pcwr_d = 1'b0; pcc_d = 1'b0; bne_d = 1'b0; iord_d = 1'b0;
    mrd_d  = 1'b0; mwr_d = 1'b0; rdst_d = 1'b0; m2r_d = 1'b0;
    rwr_d  = 1'b0; asa_d = 1'b0; done_d = 1'b0;
    asb_d  = 2'b00; pcs_d = 2'b00; aluop_d = 3'b000;
    case (state_d)
      S_FETCH:    begin mrd_d = 1'b1; asb_d = 2'b01; end
      S_DECODE:   asb_d = 2'b11;
      S_MEM_ADDR: begin asa_d = 1'b1; asb_d = 2'b10; end
      S_MEM_RD:   begin mrd_d = 1'b1; iord_d = 1'b1; end
      S_MEM_WB:   begin rwr_d = 1'b1; m2r_d = 1'b1; done_d = 1'b1; end
      S_MEM_WR:   begin mwr_d = 1'b1; iord_d = 1'b1; end
      S_R_EXEC:   begin asa_d = 1'b1; aluop_d = 3'b010; end
      S_R_WB:     begin rwr_d = 1'b1; rdst_d = 1'b1; done_d = 1'b1; end
      S_BRANCH: begin
        asa_d   = 1'b1;
        aluop_d = 3'b001;
        pcc_d   = 1'b1;
        pcs_d   = 2'b01;
        bne_d   = (op_d == OP_BNE);
        done_d  = 1'b1;
      end
      S_JUMP:     begin pcwr_d = 1'b1; pcs_d = 2'b10; done_d = 1'b1; end
      S_I_EXEC: begin
        asa_d = 1'b1;
        asb_d = 2'b10;
        case (op_d)
          OP_ANDI:           aluop_d = 3'b100;
          OP_ORI:            aluop_d = 3'b101;
          OP_SLTI, OP_SLTIU: aluop_d = 3'b110;
          default:           aluop_d = 3'b000;
        endcase
      end
      S_I_WB:     begin rwr_d = 1'b1; done_d = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= 6'd0;
      pcwr_q  <= 1'b0; pcc_q <= 1'b0; bne_q <= 1'b0; iord_q <= 1'b0;
      mrd_q   <= 1'b0; mwr_q <= 1'b0; rdst_q <= 1'b0; m2r_q <= 1'b0;
      rwr_q   <= 1'b0; asa_q <= 1'b0; done_q <= 1'b0;
      asb_q   <= 2'b00; pcs_q <= 2'b00; aluop_q <= 3'b000;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      pcwr_q  <= pcwr_d; pcc_q <= pcc_d; bne_q <= bne_d; iord_q <= iord_d;
      mrd_q   <= mrd_d; mwr_q <= mwr_d; rdst_q <= rdst_d; m2r_q <= m2r_d;
      rwr_q   <= rwr_d; asa_q <= asa_d; done_q <= done_d;
      asb_q   <= asb_d; pcs_q <= pcs_d; aluop_q <= aluop_d;
    end
  end

  // Strobes that depend on the handshake in the current cycle cannot be registered.
  logic fetch_ok, wr_ok, decode_nop;
  assign fetch_ok = (state_q == S_FETCH) && mem_ready;
  assign wr_ok    = (state_q == S_MEM_WR) && mem_ready;
`ifdef MCTRL_ILLEGAL_TRAP_EN
  assign decode_nop = 1'b0;
`else
  assign decode_nop = (state_q == S_DECODE) && !op_legal;
`endif

  assign PCWrite     = pcwr_q | fetch_ok;
  assign IRWrite     = fetch_ok;
  assign instr_done  = done_q | wr_ok | decode_nop;
  assign PCWriteCond = pcc_q;
  assign BranchNe    = bne_q;
  assign IorD        = iord_q;
  assign MemRead     = mrd_q;
  assign MemWrite    = mwr_q;
  assign RegDst      = rdst_q;
  assign MemtoReg    = m2r_q;
  assign RegWrite    = rwr_q;
  assign ALUSrcA     = asa_q;
  assign ALUSrcB     = asb_q;
  assign PCSource    = pcs_q;
  assign ALUOp       = aluop_q;
  assign state       = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-cycle expected output vectors queued by the driver, checked at negedge.
// Honours MCTRL_ILLEGAL_TRAP_EN the same way as the design.

module tb_mips_multicycle_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  logic [5:0] opcode;
  logic mem_ready;
  logic PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite;
  logic RegDst, MemtoReg, RegWrite, ALUSrcA, instr_done;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic [3:0] state;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .ALUOp(ALUOp), .instr_done(instr_done), .state(state)
  );

  logic [22:0] dut_vec;
  assign dut_vec = {PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
                    RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp,
                    instr_done, state};

  typedef struct packed {
    logic [5:0]      op;
    logic [9:0]      mr;   // mem_ready for cycle c is mr[c]
    logic [3:0]      len;
    logic [0:9][3:0] st;   // expected state per cycle, from FETCH entry
  } vec_t;

  vec_t vecs[16];
  logic [22:0] expq[$];
  int errors = 0;
  int checks = 0;
  int ncyc = 0;

  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b000010,
      6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b001010, 6'b001011: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Output table per state, straight from the state descriptions.
  function automatic logic [22:0] exp_out(input logic [3:0] st, input logic [5:0] op,
                                          input logic mr, input logic [5:0] cur);
    logic pcw, pcc, bne, iord, mrd, mwr, irw, rdst, m2r, rwr, asa, done;
    logic [1:0] asb, pcs;
    logic [2:0] aop;
    {pcw, pcc, bne, iord, mrd, mwr, irw, rdst, m2r, rwr, asa, done} = '0;
    asb = 2'b00; pcs = 2'b00; aop = 3'b000;
    case (st)
      4'd1: begin mrd = 1; asb = 2'b01; if (mr) begin irw = 1; pcw = 1; end end
      4'd2: begin
        asb = 2'b11;
`ifndef MCTRL_ILLEGAL_TRAP_EN
        done = !is_legal(cur);
`endif
      end
      4'd3: begin asa = 1; asb = 2'b10; end
      4'd4: begin mrd = 1; iord = 1; end
      4'd5: begin rwr = 1; m2r = 1; done = 1; end
      4'd6: begin mwr = 1; iord = 1; done = mr; end
      4'd7: begin asa = 1; aop = 3'b010; end
      4'd8: begin rwr = 1; rdst = 1; done = 1; end
      4'd9: begin asa = 1; aop = 3'b001; pcc = 1; pcs = 2'b01; bne = (op == 6'b000101); done = 1; end
      4'd10: begin pcw = 1; pcs = 2'b10; done = 1; end
      4'd11: begin
        asa = 1; asb = 2'b10;
        if (op == 6'b001100) aop = 3'b100;
        else if (op == 6'b001101) aop = 3'b101;
        else if (op == 6'b001010 || op == 6'b001011) aop = 3'b110;
        else aop = 3'b000;
      end
      4'd12: begin rwr = 1; done = 1; end
      default: ;
    endcase
    return {pcw, pcc, bne, iord, mrd, mwr, irw, rdst, m2r, rwr, asa, asb, pcs, aop, done, st};
  endfunction

  task automatic check(input string nm, input logic [22:0] got, input logic [22:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %b (state %0d) expected %b (state %0d)",
               nm, ncyc, got, got[3:0], exp, exp[3:0]);
    end
  endtask

  // Opcode in the IR after DECODE is scrambled so anything that ignores op_q shows up.
  task automatic run(input vec_t v);
    for (int c = 0; c < int'(v.len); c++) begin
      @(posedge clk);
      #1;
      mem_ready = v.mr[c];
      opcode = (v.st[c] == 4'd1 || v.st[c] == 4'd2) ? v.op : (v.op ^ 6'b001000);
      expq.push_back(exp_out(v.st[c], v.op, v.mr[c], opcode));
    end
  endtask

  task automatic push_idle();
    expq.push_back(exp_out(4'd0, 6'd0, mem_ready, opcode));
  endtask

  initial begin
    vecs[0]  = '{op: 6'b000000, mr: 10'h3FF, len: 4'd4, st: {4'd1, 4'd2, 4'd7, 4'd8, 24'd0}};
    vecs[1]  = '{op: 6'b000000, mr: 10'h3F3, len: 4'd4, st: {4'd1, 4'd2, 4'd7, 4'd8, 24'd0}};
    vecs[2]  = '{op: 6'b100011, mr: 10'h3E3, len: 4'd7, st: {4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd5, 12'd0}};
    vecs[3]  = '{op: 6'b101011, mr: 10'h3F7, len: 4'd5, st: {4'd1, 4'd2, 4'd3, 4'd6, 4'd6, 20'd0}};
    vecs[4]  = '{op: 6'b100011, mr: 10'h3FF, len: 4'd5, st: {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 20'd0}};
    vecs[5]  = '{op: 6'b000101, mr: 10'h3FB, len: 4'd3, st: {4'd1, 4'd2, 4'd9, 28'd0}};
    vecs[6]  = '{op: 6'b000100, mr: 10'h3FF, len: 4'd3, st: {4'd1, 4'd2, 4'd9, 28'd0}};
    vecs[7]  = '{op: 6'b000010, mr: 10'h3FF, len: 4'd3, st: {4'd1, 4'd2, 4'd10, 28'd0}};
    vecs[8]  = '{op: 6'b001101, mr: 10'h3FF, len: 4'd4, st: {4'd1, 4'd2, 4'd11, 4'd12, 24'd0}};
    vecs[9]  = '{op: 6'b001010, mr: 10'h3FF, len: 4'd4, st: {4'd1, 4'd2, 4'd11, 4'd12, 24'd0}};
    vecs[10] = '{op: 6'b001000, mr: 10'h3FC, len: 4'd6, st: {4'd1, 4'd1, 4'd1, 4'd2, 4'd11, 4'd12, 16'd0}};
    vecs[11] = '{op: 6'b001100, mr: 10'h3FF, len: 4'd4, st: {4'd1, 4'd2, 4'd11, 4'd12, 24'd0}};
    vecs[12] = '{op: 6'b001011, mr: 10'h3FF, len: 4'd4, st: {4'd1, 4'd2, 4'd11, 4'd12, 24'd0}};
    vecs[13] = '{op: 6'b001001, mr: 10'h3FF, len: 4'd4, st: {4'd1, 4'd2, 4'd11, 4'd12, 24'd0}};
    vecs[14] = '{op: 6'b101011, mr: 10'h3FF, len: 4'd4, st: {4'd1, 4'd2, 4'd3, 4'd6, 24'd0}};
    vecs[15] = '{op: 6'b000000, mr: 10'h3FE, len: 4'd5, st: {4'd1, 4'd1, 4'd2, 4'd7, 4'd8, 20'd0}};

    reset_n = 1'b0;
    mem_ready = 1'b0;
    opcode = 6'd0;

    fork
      forever begin
        @(negedge clk);
        ncyc++;
        if (expq.size() > 0) check("cycle", dut_vec, expq.pop_front());
      end
    join_none

    #3;
    check("reset_state", dut_vec, 23'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    push_idle();

    for (int i = 0; i < 16; i++) run(vecs[i]);

    // lw stalled in MEM_RD, then reset mid-cycle: abandoned, restart via IDLE -> FETCH.
    run('{op: 6'b100011, mr: 10'h3E7, len: 4'd5, st: {4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 20'd0}});
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_mid_memrd", dut_vec, 23'd0);
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    check("reset_held", dut_vec, 23'd0);
    reset_n = 1'b1;
    push_idle();
    run(vecs[0]);

    run('{op: 6'b111111, mr: 10'h3FF, len: 4'd2, st: {4'd1, 4'd2, 32'd0}});
`ifdef MCTRL_ILLEGAL_TRAP_EN
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      mem_ready = c[0];
      opcode = 6'b000000;
      expq.push_back(exp_out(4'd13, 6'b111111, mem_ready, opcode));
    end
`else
    run(vecs[7]);
`endif

    for (int i = 0; i < 4 && expq.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
